// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display: digit select, active-low anodes
// and a double-buffered display value that only changes at frame boundaries.
//
// state    | meaning
// ST_IDLE  | en low, anodes off, counter and select held at zero
// ST_BLANK | dead time at the start of a slot, anodes off
// ST_SHOW  | selected digit driven unless leading-zero suppressed
module seg_scan_ctrl #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        lz_blank,
    input  logic        load,
    input  logic [15:0] din,
    output logic        load_ack,
    output logic [15:0] digit,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sel_n;
    logic [3:0]    an_n;
    logic          tick_n;
    logic          show_n;
    logic          commit;
    logic [15:0]   pend;
    logic          pend_v;
    logic [15:0]   digit_n;
    logic [3:0]    supp;

    always_comb begin
        cnt_n  = '0;
        sel_n  = 2'd0;
        tick_n = 1'b0;
        if (state != ST_IDLE && en) begin
            if (cnt == CNT_MAX) begin
                cnt_n  = '0;
                sel_n  = sel + 2'd1;
                tick_n = (sel == 2'd3);
            end else begin
                cnt_n = cnt + 1'b1;
                sel_n = sel;
            end
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign show_n = 1'b1;
        end else begin : g_blank
            assign show_n = (cnt_n >= BLANK_W);
        end
    endgenerate

    always_comb begin
        state_n = ST_IDLE;
        if (en) begin
            state_n = show_n ? ST_SHOW : ST_BLANK;
        end
    end

    // A load arriving on the commit edge bypasses the pending register so the newest value wins.
    assign commit  = pend_v && ((state == ST_IDLE) || tick_n);
    assign digit_n = commit ? (load ? din : pend) : digit;

    // Suppression looks at the value that will be displayed, keeping an and digit consistent.
    always_comb begin
        supp    = 4'b0000;
        supp[1] = lz_blank && (digit_n[15:4] == 12'h000);
        supp[2] = lz_blank && (digit_n[15:8] == 8'h00);
        supp[3] = lz_blank && (digit_n[15:12] == 4'h0);
    end

    always_comb begin
        an_n = 4'hF;
        if (en && show_n && !supp[sel_n]) begin
            an_n = ~(4'b0001 << sel_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sel        <= 2'd0;
            an         <= 4'hF;
            frame_tick <= 1'b0;
            load_ack   <= 1'b0;
            digit      <= 16'h0000;
            pend       <= 16'h0000;
            pend_v     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            an         <= an_n;
            frame_tick <= tick_n;
            load_ack   <= commit;
            digit      <= digit_n;
            if (commit) begin
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= din;
                pend_v <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit 7-segment display. It drives the 2-bit select of the 4:1 nibble mux and the active-low digit anodes, and holds a double-buffered copy of the four displayed nibbles. New values are loaded through a handshake and committed only at frame boundaries, so a displayed number never tears. It sits between the counter/debouncer datapath and the mux + segment decoder.

## Interface
- PRESCALE, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: dead-time cycles at the start of each slot with all anodes off; 0 ≤ BLANK_CYCLES < PRESCALE.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low forces the idle state.
- lz_blank  in  1  leading-zero suppression enable.
- load  in  1  one-cycle request to capture din.
- din  in  16  new display value; digit0 = din[3:0], digit3 = din[15:12].
- load_ack  out  1  one-cycle pulse when the pending value is committed to digit.
- digit  out  16  committed nibbles; digit[4i+3:4i] feeds mux input i (J=0, K=1, L=2, M=3).
- sel  out  2  mux select and current digit index.
- an  out  4  anode enables, active-low, one-hot-low or all-high.
- frame_tick  out  1  one-cycle pulse at each sel 3→0 wrap.

## Operation
- States:
  - IDLE: en=0. an=1111, sel=0, cnt=0.
  - BLANK: cnt < BLANK_CYCLES. an=1111.
  - SHOW: cnt ≥ BLANK_CYCLES. an[sel]=0 unless the digit is suppressed.
- Transitions:
  - IDLE→BLANK when en is sampled high, or IDLE→SHOW if BLANK_CYCLES=0.
  - Any active state → IDLE when en is sampled low, at any point in a slot.
- Slot counter: cnt counts 0..PRESCALE-1, width $clog2(PRESCALE). At PRESCALE-1 it wraps to 0 and sel increments modulo 4.
- frame_tick=1 on the cycle where cnt=0 and sel=0 after a 3→0 wrap. It is not asserted on the IDLE exit.
- Load buffer:
  - load=1 captures din into a pending register and sets pend_v.
  - A second load before commit overwrites the pending value; the last one wins.
- Commit happens on the frame_tick cycle, or on any IDLE cycle, if pend_v=1. It sets digit←pending, clears pend_v and pulses load_ack.
- load on the same cycle as a commit: din goes straight to digit (newest wins), pend_v=0, load_ack=1.
- Leading-zero suppression (lz_blank=1): digit position k∈{3,2,1} is suppressed when nibbles k..3 are all zero. Its anode stays high during SHOW. Digit 0 is never suppressed. Suppression is evaluated on the committed digit, not on din.
- sel keeps stepping during BLANK and through suppressed slots, so the frame period is always 4·PRESCALE cycles.

## Timing
- Reset values: sel=00, an=1111, digit=0x0000, load_ack=0, frame_tick=0. Internally pend_v=0, cnt=0, state IDLE.
- an, sel, load_ack and frame_tick are registered (glitch-free). an changes on the same edge that cnt/sel change.
- en rise sampled at edge E: after E, cnt=0, sel=0 and state=BLANK. The first anode goes low at E+BLANK_CYCLES.
- sel changes only at slot boundaries. an is 1111 for exactly BLANK_CYCLES cycles after every sel change, so no two anodes are ever low at once.
- en fall sampled at edge E: after E, an=1111, sel=0, cnt=0. A pending value commits on the next IDLE cycle, which is E+1 at the earliest.
- Commit latency while scanning: at most 4·PRESCALE cycles from load to load_ack.
- Commit latency in IDLE: load at edge E, then load_ack=1 and digit updated after E+1.
- Reset asserted mid-operation returns everything to reset values immediately and discards any pending value.

## Test plan
Directed tests use PRESCALE=8, BLANK_CYCLES=2.
- Scan sequence: reset, en=1, digit=0x1234. Require sel cycles 0,1,2,3,0 every 8 cycles. Each slot shows an=1111 for 2 cycles, then an=1110/1101/1011/0111 for 6 cycles. frame_tick pulses every 32 cycles.
- Deferred commit: scanning, load din=0xABCD at cnt=3 of sel=1. Require digit to stay 0x1234 until the frame_tick cycle, then digit=0xABCD with load_ack=1 on exactly that cycle.
- Overwrite and collision:
  - Two loads (0x1111, then 0x2222) within one frame: a single load_ack, digit=0x2222.
  - load din=0x3333 on the frame_tick cycle: digit=0x3333, no further load_ack.
- Leading-zero suppression: lz_blank=1, digit=0x0050. Require an to stay 1111 in sel=3 and sel=2 slots, show sel=1 and sel=0, and keep the 32-cycle period. digit=0x0000 shows only digit 0.
- IDLE and enable: en=0, load 0x00FF. Require load_ack one cycle later, an=1111 throughout. Dropping en mid-SHOW gives an=1111, sel=0 on the next cycle.
- Async reset: assert rst mid-slot with pend_v=1 and no clock edge. Require an=1111, sel=0, digit=0 immediately. After release there is no load_ack.
